// File: rtl/seq_restoring_divider.sv
// Iterative restoring divider: 2*WIDTH-bit dividend by WIDTH-bit divisor,
// one quotient bit per clock, valid/ready on both sides.
module seq_restoring_divider #(
    parameter int WIDTH = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [2*WIDTH-1:0]   dividend,
    input  logic [WIDTH-1:0]     divisor,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   quotient,
    output logic [WIDTH-1:0]     remainder,
    output logic                 div_by_zero
);

    localparam int DW = 2 * WIDTH;
    localparam int CW = $clog2(DW + 1);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    state_t            state_q, state_d;
    logic [WIDTH:0]    r_q, r_d;
    logic [DW-1:0]     q_q, q_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [WIDTH-1:0]  div_q, div_d;
    logic [DW-1:0]     quot_q, quot_d;
    logic [WIDTH-1:0]  rem_q, rem_d;
    logic              dbz_q, dbz_d;

    logic [WIDTH:0]    shifted;
    logic [WIDTH:0]    diff;

    // Partial remainder stays below the divisor, so diff's top bit is its sign.
    assign shifted = {r_q[WIDTH-1:0], q_q[DW-1]};
    assign diff    = shifted - {1'b0, div_q};

    always_comb begin
        state_d = state_q;
        r_d     = r_q;
        q_d     = q_q;
        cnt_d   = cnt_q;
        div_d   = div_q;
        quot_d  = quot_q;
        rem_d   = rem_q;
        dbz_d   = dbz_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    div_d = divisor;
                    if (divisor == '0) begin
                        state_d = DONE;
                        quot_d  = '1;
                        rem_d   = '0;
                        dbz_d   = 1'b1;
                    end else begin
                        state_d = CALC;
                        r_d     = '0;
                        q_d     = dividend;
                        cnt_d   = CW'(DW);
                    end
                end
            end
            CALC: begin
                if (diff[WIDTH]) begin
                    r_d = shifted;
                end else begin
                    r_d = diff;
                end
                q_d   = {q_q[DW-2:0], ~diff[WIDTH]};
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d = DONE;
                    quot_d  = q_d;
                    rem_d   = r_d[WIDTH-1:0];
                    dbz_d   = 1'b0;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            r_q     <= '0;
            q_q     <= '0;
            cnt_q   <= '0;
            div_q   <= '0;
            quot_q  <= '0;
            rem_q   <= '0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            r_q     <= r_d;
            q_q     <= q_d;
            cnt_q   <= cnt_d;
            div_q   <= div_d;
            quot_q  <= quot_d;
            rem_q   <= rem_d;
            dbz_q   <= dbz_d;
        end
    end

    assign in_ready    = (state_q == IDLE);
    assign out_valid   = (state_q == DONE);
    assign quotient    = quot_q;
    assign remainder   = rem_q;
    assign div_by_zero = dbz_q;

endmodule
